exc_commit: RTL and testbench
=============================

EXC_COMMIT -- requirements
Module: exc_commit

Interface
REQ-001 The block SHALL have one clock and a synchronous active-low reset, with clock and reset named as elsewhere in the codebase: clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-low; 0 at a rising edge clears state.
REQ-004 ExcCodeM  input  [6:2]  exception code carried to M stage; 5'd0 = no exception.
REQ-005 PCM  input  32  PC of the M-stage instruction.
REQ-006 BDM  input  1  M-stage instruction sits in a branch delay slot.
REQ-007 HWInt  input  [7:2]  six level-sensitive hardware interrupt lines.
REQ-008 We  input  1  mtc0 write enable from M stage.
REQ-009 A1  input  5  CP0 read register number (mfc0).
REQ-010 A2  input  5  CP0 write register number (mtc0).
REQ-011 DIn  input  32  mtc0 write data.
REQ-012 EretM  input  1  eret instruction in M stage.
REQ-013 DOut  output  32  combinational read of register A1.
REQ-014 EPCOut  output  32  current EPC value, eret return target.
REQ-015 ExcReq  output  1  combinational; flush pipeline and redirect fetch to the handler this cycle.
REQ-016 IntReq  output  1  combinational; the ExcReq cause is an interrupt.

Function
REQ-017 The block SHALL hold SR (reg 12), Cause (reg 13), EPC (reg 14) and read-only PRId (reg 15, constant 32'h4C57_0001).
- SR fields: IM=[15:10], EXL=[1], IE=[0]; other bits read 0.
- Cause fields: BD=[31], IP=[15:10], ExcCode=[6:2]; other bits read 0.
REQ-018 IntReq SHALL equal |(HWInt & SR.IM) & SR.IE & !SR.EXL.
REQ-019 The exception-taken condition SHALL be (ExcCodeM != 0) & !SR.EXL.
- ExcReq = IntReq | exception-taken.
REQ-020 When IntReq and an exception are both present, the interrupt SHALL take priority.
- The committed ExcCode is 5'd0 for an interrupt, otherwise ExcCodeM.
REQ-021 On a rising edge with ExcReq=1, the block SHALL:
- set SR.EXL=1;
- load Cause.ExcCode and Cause.BD=BDM;
- load EPC = BDM ? PCM-4 : PCM, with bits [1:0] forced to 0.
REQ-022 Cause.IP SHALL be loaded with HWInt on every non-reset edge, independent of all other events.
REQ-023 On a rising edge with EretM=1 and ExcReq=0, the block SHALL clear SR.EXL; all other state is unchanged.
REQ-024 On a rising edge with We=1 and ExcReq=0, the block SHALL update the register selected by A2:
- A2=12: SR IM/EXL/IE from DIn.
- A2=14: EPC = {DIn[31:2],2'b00}.
- A2=13, A2=15 or any other A2: write ignored.
REQ-025 ExcReq=1 SHALL suppress a same-cycle mtc0 write and a same-cycle eret.
REQ-026 A simultaneous eret and mtc0 to SR SHALL apply the mtc0 data first, then force EXL=0.
REQ-027 DOut SHALL return the pre-edge register value, so a read-during-write to the same register returns old data.
- Unimplemented register numbers return 32'h0.
REQ-028 EPCOut SHALL equal EPC, combinationally from the register.
REQ-029 While SR.EXL=1, further exceptions and interrupts SHALL be ignored.
- Ignored means: no state change and ExcReq=0.

Reset
REQ-030 When reset=0 at a rising edge, SR, Cause and EPC SHALL become 32'h0.
- ExcReq and IntReq are therefore 0 in the following cycle regardless of HWInt.
REQ-031 Reset SHALL override ExcReq, eret and mtc0 in the same cycle.
- Reset mid-handler (EXL=1) returns EXL to 0.

Verification
REQ-032 Write SR=32'h0000_0401, then assert HWInt=6'b000001 -> IntReq=ExcReq=1 immediately.
- Next cycle: EXL=1, Cause.ExcCode=0, EPC=PCM, IntReq=0.
REQ-033 ExcCodeM=5'd10, PCM=32'h0000_3010, BDM=1 -> ExcReq=1.
- Next edge: EPC=32'h0000_300C, Cause=32'h8000_0028 (with HWInt=0).
REQ-034 With EXL=1, apply ExcCodeM=5'd4 -> ExcReq=0 and EPC unchanged; then EretM=1 -> EXL=0 next edge.
REQ-035 mtc0 A2=14 DIn=32'h0000_3007 with ExcReq=0 -> EPCOut=32'h0000_3004; same-cycle mfc0 A1=14 returns the old EPC.
REQ-036 Interrupt pending (IM/IE enabled) plus ExcCodeM=5'd12 in the same cycle -> Cause.ExcCode=0; a same-cycle mtc0 to SR is dropped.
REQ-037 reset=0 while EXL=1 and HWInt=6'h3F -> all registers 0 next cycle; DOut(A1=15)=32'h4C57_0001.

Source files
------------

// File: rtl/exc_commit_if.sv
// Bundle of M-stage exception/CP0 signals between the pipeline and exc_commit.
// The master (pipeline) drives the requests; the slave (exc_commit) returns reads and redirects.
interface exc_commit_if;
   logic [6:2]  ExcCodeM;
   logic [31:0] PCM;
   logic        BDM;
   logic [7:2]  HWInt;
   logic        We;
   logic [4:0]  A1;
   logic [4:0]  A2;
   logic [31:0] DIn;
   logic        EretM;
   logic [31:0] DOut;
   logic [31:0] EPCOut;
   logic        ExcReq;
   logic        IntReq;

   modport master (
      output ExcCodeM, PCM, BDM, HWInt, We, A1, A2, DIn, EretM,
      input  DOut, EPCOut, ExcReq, IntReq
   );

   modport slave (
      input  ExcCodeM, PCM, BDM, HWInt, We, A1, A2, DIn, EretM,
      output DOut, EPCOut, ExcReq, IntReq
   );
endinterface

// File: rtl/exc_commit.sv
// CP0 exception commit: holds SR/Cause/EPC/PRId, decides interrupt/exception entry,
// and services mtc0, mfc0 and eret from the M stage.
module exc_commit (
   input  logic         clk,
   input  logic         reset,
   exc_commit_if.slave  bus
);

   localparam logic [31:0] PRID_VALUE = 32'h4C57_0001;

   // Only the architecturally visible fields are stored; everything else reads as zero.
   logic [5:0]  srImQ, srImD;
   logic        srExlQ, srExlD;
   logic        srIeQ, srIeD;
   logic        causeBdQ, causeBdD;
   logic [5:0]  causeIpQ, causeIpD;
   logic [4:0]  causeExcQ, causeExcD;
   logic [31:0] epcQ, epcD;

   logic        intReq;
   logic        excTaken;
   logic        excReq;
   logic [31:0] srValue;
   logic [31:0] causeValue;

   assign intReq   = (|(bus.HWInt & srImQ)) & srIeQ & ~srExlQ;
   assign excTaken = (bus.ExcCodeM != 5'd0) & ~srExlQ;
   assign excReq   = intReq | excTaken;

   assign bus.IntReq = intReq;
   assign bus.ExcReq = excReq;
   assign bus.EPCOut = epcQ;

   assign srValue    = {16'h0000, srImQ, 8'h00, srExlQ, srIeQ};
   assign causeValue = {causeBdQ, 15'h0000, causeIpQ, 3'b000, causeExcQ, 2'b00};

   // mfc0 sees pre-edge state, so a same-cycle mtc0 to the same register returns old data.
   always_comb begin
      bus.DOut = 32'h0000_0000;
      case (bus.A1)
         5'd12:   bus.DOut = srValue;
         5'd13:   bus.DOut = causeValue;
         5'd14:   bus.DOut = epcQ;
         5'd15:   bus.DOut = PRID_VALUE;
         default: bus.DOut = 32'h0000_0000;
      endcase
   end

   always_comb begin
      srImD     = srImQ;
      srExlD    = srExlQ;
      srIeD     = srIeQ;
      causeBdD  = causeBdQ;
      causeIpD  = bus.HWInt;
      causeExcD = causeExcQ;
      epcD      = epcQ;

      if (excReq) begin
         srExlD    = 1'b1;
         causeBdD  = bus.BDM;
         causeExcD = intReq ? 5'd0 : bus.ExcCodeM;
         epcD      = (bus.BDM ? (bus.PCM - 32'd4) : bus.PCM) & 32'hFFFF_FFFC;
      end else begin
         if (bus.We) begin
            case (bus.A2)
               5'd12: begin
                  srImD  = bus.DIn[15:10];
                  srExlD = bus.DIn[1];
                  srIeD  = bus.DIn[0];
               end
               5'd14:   epcD = {bus.DIn[31:2], 2'b00};
               default: ;
            endcase
         end
         // eret is applied after mtc0 so a combined SR write still leaves EXL clear.
         if (bus.EretM) begin
            srExlD = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         srImQ     <= 6'd0;
         srExlQ    <= 1'b0;
         srIeQ     <= 1'b0;
         causeBdQ  <= 1'b0;
         causeIpQ  <= 6'd0;
         causeExcQ <= 5'd0;
         epcQ      <= 32'h0000_0000;
      end else begin
         srImQ     <= srImD;
         srExlQ    <= srExlD;
         srIeQ     <= srIeD;
         causeBdQ  <= causeBdD;
         causeIpQ  <= causeIpD;
         causeExcQ <= causeExcD;
         epcQ      <= epcD;
      end
   end

endmodule

// File: tb/tb_exc_commit.sv
// Directed self-checking bench for exc_commit: interrupt/exception entry, EXL masking,
// mtc0/mfc0/eret interaction and reset behaviour, with hand-computed expectations.
module tb_exc_commit;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   exc_commit_if bus ();

   exc_commit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Inputs change 1 time unit after the rising edge and outputs are sampled there too.
   task automatic stepClk();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus();
      bus.ExcCodeM = 5'd0;
      bus.PCM      = 32'h0000_0000;
      bus.BDM      = 1'b0;
      bus.HWInt    = 6'd0;
      bus.We       = 1'b0;
      bus.A1       = 5'd0;
      bus.A2       = 5'd0;
      bus.DIn      = 32'h0000_0000;
      bus.EretM    = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] obs;
      applyStimulus();
      reset     = 1'b0;
      bus.HWInt = 6'h3F;
      stepClk();
      stepClk();
      bus.A1 = 5'd12; #1; obs = bus.DOut; checks++;
      if (obs !== 32'h0) begin failures++; $display("[TB] FAIL reset_sr got=%h exp=%h", obs, 32'h0); end
      bus.A1 = 5'd13; #1; obs = bus.DOut; checks++;
      if (obs !== 32'h0) begin failures++; $display("[TB] FAIL reset_cause got=%h exp=%h", obs, 32'h0); end
      checks++;
      if (bus.EPCOut !== 32'h0) begin failures++; $display("[TB] FAIL reset_epc got=%h exp=%h", bus.EPCOut, 32'h0); end
      checks++;
      if ({bus.ExcReq, bus.IntReq} !== 2'b00) begin
         failures++; $display("[TB] FAIL reset_req got=%b exp=%b", {bus.ExcReq, bus.IntReq}, 2'b00);
      end
      reset     = 1'b1;
      bus.HWInt = 6'd0;
      stepClk();
   endtask

   task automatic test_interrupt();
      logic [31:0] obs;
      applyStimulus();
      bus.We = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0401;
      stepClk();
      bus.We = 1'b0;
      bus.A1 = 5'd12; #1; obs = bus.DOut; checks++;
      if (obs !== 32'h0000_0401) begin failures++; $display("[TB] FAIL int_sr_write got=%h exp=%h", obs, 32'h0000_0401); end
      bus.HWInt = 6'b000001; bus.PCM = 32'h0000_1000;
      #1; checks++;
      if ({bus.IntReq, bus.ExcReq} !== 2'b11) begin
         failures++; $display("[TB] FAIL int_request got=%b exp=%b", {bus.IntReq, bus.ExcReq}, 2'b11);
      end
      stepClk();
      bus.A1 = 5'd12; #1; obs = bus.DOut; checks++;
      if (obs !== 32'h0000_0403) begin failures++; $display("[TB] FAIL int_sr_exl got=%h exp=%h", obs, 32'h0000_0403); end
      bus.A1 = 5'd13; #1; obs = bus.DOut; checks++;
      if (obs !== 32'h0000_0400) begin failures++; $display("[TB] FAIL int_cause got=%h exp=%h", obs, 32'h0000_0400); end
      checks++;
      if (bus.EPCOut !== 32'h0000_1000) begin failures++; $display("[TB] FAIL int_epc got=%h exp=%h", bus.EPCOut, 32'h0000_1000); end
      checks++;
      if ({bus.IntReq, bus.ExcReq} !== 2'b00) begin
         failures++; $display("[TB] FAIL int_masked got=%b exp=%b", {bus.IntReq, bus.ExcReq}, 2'b00);
      end
      bus.EretM = 1'b1; bus.HWInt = 6'd0;
      stepClk();
      bus.EretM = 1'b0;
      bus.A1 = 5'd12; #1; obs = bus.DOut; checks++;
      if (obs !== 32'h0000_0401) begin failures++; $display("[TB] FAIL int_eret_sr got=%h exp=%h", obs, 32'h0000_0401); end
      bus.We = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0000;
      stepClk();
      bus.We = 1'b0;
   endtask

   task automatic test_exception_bd();
      logic [31:0] obs;
      applyStimulus();
      bus.ExcCodeM = 5'd10; bus.PCM = 32'h0000_3010; bus.BDM = 1'b1;
      #1; checks++;
      if ({bus.ExcReq, bus.IntReq} !== 2'b10) begin
         failures++; $display("[TB] FAIL exc_request got=%b exp=%b", {bus.ExcReq, bus.IntReq}, 2'b10);
      end
      stepClk();
      bus.ExcCodeM = 5'd0; bus.BDM = 1'b0;
      checks++;
      if (bus.EPCOut !== 32'h0000_300C) begin failures++; $display("[TB] FAIL exc_epc_bd got=%h exp=%h", bus.EPCOut, 32'h0000_300C); end
      bus.A1 = 5'd13; #1; obs = bus.DOut; checks++;
      if (obs !== 32'h8000_0028) begin failures++; $display("[TB] FAIL exc_cause got=%h exp=%h", obs, 32'h8000_0028); end
      bus.A1 = 5'd12; #1; obs = bus.DOut; checks++;
      if (obs !== 32'h0000_0002) begin failures++; $display("[TB] FAIL exc_sr_exl got=%h exp=%h", obs, 32'h0000_0002); end
   endtask

   task automatic test_exl_masking();
      logic [31:0] obs;
      applyStimulus();
      bus.ExcCodeM = 5'd4; bus.PCM = 32'h0000_5000;
      #1; checks++;
      if (bus.ExcReq !== 1'b0) begin failures++; $display("[TB] FAIL exl_excreq got=%b exp=%b", bus.ExcReq, 1'b0); end
      stepClk();
      checks++;
      if (bus.EPCOut !== 32'h0000_300C) begin failures++; $display("[TB] FAIL exl_epc_hold got=%h exp=%h", bus.EPCOut, 32'h0000_300C); end
      bus.A1 = 5'd13; #1; obs = bus.DOut; checks++;
      if (obs !== 32'h8000_0028) begin failures++; $display("[TB] FAIL exl_cause_hold got=%h exp=%h", obs, 32'h8000_0028); end
      bus.ExcCodeM = 5'd0; bus.EretM = 1'b1;
      stepClk();
      bus.EretM = 1'b0;
      bus.A1 = 5'd12; #1; obs = bus.DOut; checks++;
      if (obs !== 32'h0000_0000) begin failures++; $display("[TB] FAIL exl_eret_sr got=%h exp=%h", obs, 32'h0000_0000); end
   endtask

   task automatic test_mtc0_epc();
      logic [31:0] obs;
      applyStimulus();
      bus.We = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h0000_3007; bus.A1 = 5'd14;
      #1; obs = bus.DOut; checks++;
      if (obs !== 32'h0000_300C) begin failures++; $display("[TB] FAIL mtc0_rdw_old got=%h exp=%h", obs, 32'h0000_300C); end
      stepClk();
      checks++;
      if (bus.EPCOut !== 32'h0000_3004) begin failures++; $display("[TB] FAIL mtc0_epc got=%h exp=%h", bus.EPCOut, 32'h0000_3004); end
      bus.A2 = 5'd13; bus.DIn = 32'hFFFF_FFFF;
      stepClk();
      bus.A2 = 5'd15;
      stepClk();
      bus.We = 1'b0;
      bus.A1 = 5'd13; #1; obs = bus.DOut; checks++;
      if (obs !== 32'h8000_0028) begin failures++; $display("[TB] FAIL mtc0_cause_ro got=%h exp=%h", obs, 32'h8000_0028); end
      bus.A1 = 5'd15; #1; obs = bus.DOut; checks++;
      if (obs !== 32'h4C57_0001) begin failures++; $display("[TB] FAIL mtc0_prid_ro got=%h exp=%h", obs, 32'h4C57_0001); end
      bus.A1 = 5'd20; #1; obs = bus.DOut; checks++;
      if (obs !== 32'h0) begin failures++; $display("[TB] FAIL mfc0_unimpl got=%h exp=%h", obs, 32'h0); end
   endtask

   task automatic test_priority();
      logic [31:0] obs;
      applyStimulus();
      bus.We = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_FC01;
      stepClk();
      bus.HWInt = 6'b100000; bus.ExcCodeM = 5'd12; bus.PCM = 32'h0000_4000;
      bus.We = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0000; bus.EretM = 1'b1;
      #1; checks++;
      if ({bus.IntReq, bus.ExcReq} !== 2'b11) begin
         failures++; $display("[TB] FAIL prio_request got=%b exp=%b", {bus.IntReq, bus.ExcReq}, 2'b11);
      end
      stepClk();
      applyStimulus();
      bus.A1 = 5'd13; #1; obs = bus.DOut; checks++;
      if (obs !== 32'h0000_8000) begin failures++; $display("[TB] FAIL prio_cause got=%h exp=%h", obs, 32'h0000_8000); end
      bus.A1 = 5'd12; #1; obs = bus.DOut; checks++;
      if (obs !== 32'h0000_FC03) begin failures++; $display("[TB] FAIL prio_sr_drop got=%h exp=%h", obs, 32'h0000_FC03); end
      checks++;
      if (bus.EPCOut !== 32'h0000_4000) begin failures++; $display("[TB] FAIL prio_epc got=%h exp=%h", bus.EPCOut, 32'h0000_4000); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] obs;
      applyStimulus();
      bus.EretM = 1'b1; bus.We = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0403;
      stepClk();
      applyStimulus();
      bus.A1 = 5'd12; #1; obs = bus.DOut; checks++;
      if (obs !== 32'h0000_0401) begin failures++; $display("[TB] FAIL eret_mtc0_sr got=%h exp=%h", obs, 32'h0000_0401); end
      bus.ExcCodeM = 5'd8; bus.PCM = 32'h0000_6002;
      stepClk();
      bus.ExcCodeM = 5'd0;
      checks++;
      if (bus.EPCOut !== 32'h0000_6000) begin failures++; $display("[TB] FAIL b2b_epc_align got=%h exp=%h", bus.EPCOut, 32'h0000_6000); end
   endtask

   task automatic test_reset_mid_handler();
      logic [31:0] obs;
      applyStimulus();
      reset = 1'b0; bus.HWInt = 6'h3F; bus.ExcCodeM = 5'd8;
      bus.We = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h0000_1234; bus.EretM = 1'b1;
      stepClk();
      bus.ExcCodeM = 5'd0; bus.We = 1'b0; bus.EretM = 1'b0;
      bus.A1 = 5'd12; #1; obs = bus.DOut; checks++;
      if (obs !== 32'h0) begin failures++; $display("[TB] FAIL rst_mid_sr got=%h exp=%h", obs, 32'h0); end
      bus.A1 = 5'd13; #1; obs = bus.DOut; checks++;
      if (obs !== 32'h0) begin failures++; $display("[TB] FAIL rst_mid_cause got=%h exp=%h", obs, 32'h0); end
      checks++;
      if (bus.EPCOut !== 32'h0) begin failures++; $display("[TB] FAIL rst_mid_epc got=%h exp=%h", bus.EPCOut, 32'h0); end
      bus.A1 = 5'd15; #1; obs = bus.DOut; checks++;
      if (obs !== 32'h4C57_0001) begin failures++; $display("[TB] FAIL rst_mid_prid got=%h exp=%h", obs, 32'h4C57_0001); end
      checks++;
      if ({bus.ExcReq, bus.IntReq} !== 2'b00) begin
         failures++; $display("[TB] FAIL rst_mid_req got=%b exp=%b", {bus.ExcReq, bus.IntReq}, 2'b00);
      end
      reset = 1'b1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      applyStimulus();
      #2;
      test_reset();
      test_interrupt();
      test_exception_bd();
      test_exl_masking();
      test_mtc0_epc();
      test_priority();
      test_back_to_back();
      test_reset_mid_handler();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
